// File: rtl/exit_arbiter_pkg.sv
// ============================================================================
// Module   : exit_arbiter_pkg
// Purpose  : Shared state encodings and constants for the exit arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package exit_arbiter_pkg;

    typedef enum logic [1:0] {
        EA_IDLE = 2'd0,
        EA_RUN  = 2'd1,
        EA_WAIT = 2'd2,
        EA_HOLD = 2'd3
    } ea_state_t;

    localparam int EXIT_THRESHOLD = 70;

endpackage

`default_nettype wire

// File: rtl/exit_arbiter_argmax_tracker.sv
// ============================================================================
// Module   : argmax_tracker
// Purpose  : Running argmax over one serial class-score stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module argmax_tracker #(
    parameter int BIT_SCORE = 16,
    parameter int N_CLASS   = 10,
    parameter int BIT_O     = $clog2(N_CLASS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        valid,
    input  logic signed [BIT_SCORE-1:0] score,
    input  logic                        last,
    input  logic                        freeze,
    output logic signed [BIT_SCORE-1:0] max_score,
    output logic [BIT_O-1:0]            max_idx,
    output logic                        done
);

    localparam int               CNT_W     = $clog2(N_CLASS + 1);
    localparam logic [CNT_W-1:0] c_n_class = CNT_W'(N_CLASS);

    logic [CNT_W-1:0]            r_cnt;
    logic signed [BIT_SCORE-1:0] r_max;
    logic [BIT_O-1:0]            r_idx;
    logic                        r_done;

    logic w_open;
    logic w_take;
    logic w_upd;

    assign w_open = valid & ~freeze & ~clear & ~r_done;
    assign w_take = w_open & (r_cnt < c_n_class);
    assign w_upd  = w_take & ((r_cnt == '0) | (score > r_max));

    // Outputs already include the beat of the current cycle so a deciding
    // last beat is judged on its own score as well.
    assign max_score = w_upd ? score : r_max;
    assign max_idx   = w_upd ? r_cnt[BIT_O-1:0] : r_idx;
    assign done      = r_done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_max  <= '0;
            r_idx  <= '0;
            r_done <= 1'b0;
        end else if (clear) begin
            r_cnt  <= '0;
            r_max  <= '0;
            r_idx  <= '0;
            r_done <= 1'b0;
        end else begin
            if (w_take) begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_max <= max_score;
                r_idx <= max_idx;
            end
            if (w_open & last) begin
                r_done <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/exit_arbiter.sv
// ============================================================================
// Module   : exit_arbiter
// Purpose  : Chooses between early-exit and full-path class decisions.
// Revision : 1.0
// ============================================================================
`default_nettype none

module exit_arbiter
    import exit_arbiter_pkg::*;
#(
    parameter int BIT_SCORE = 16,
    parameter int N_CLASS   = 10,
    parameter int BIT_O     = $clog2(N_CLASS),
    parameter int THRESHOLD = EXIT_THRESHOLD
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 early_valid,
    input  logic [BIT_SCORE-1:0] early_score,
    input  logic                 early_last,
    input  logic                 full_valid,
    input  logic [BIT_SCORE-1:0] full_score,
    input  logic                 full_last,
    output logic                 abort,
    output logic                 class_valid,
    input  logic                 class_ready,
    output logic [BIT_O-1:0]     class_out,
    output logic                 class_early,
    output logic [BIT_SCORE-1:0] class_score
);

    localparam logic signed [BIT_SCORE-1:0] c_threshold = BIT_SCORE'(THRESHOLD);

    ea_state_t                   r_state;
    logic                        r_abort;
    logic                        r_valid;
    logic                        r_early;
    logic [BIT_O-1:0]            r_class;
    logic [BIT_SCORE-1:0]        r_score;

    logic                        w_active;
    logic                        w_clear;
    logic                        w_e_end;
    logic                        w_f_end;
    logic signed [BIT_SCORE-1:0] w_e_max;
    logic signed [BIT_SCORE-1:0] w_f_max;
    logic [BIT_O-1:0]            w_e_idx;
    logic [BIT_O-1:0]            w_f_idx;
    logic                        w_e_done;
    logic                        w_f_done;

    assign w_active = (r_state == EA_RUN) | (r_state == EA_WAIT);
    assign w_clear  = (r_state == EA_IDLE) | (start & w_active);
    assign w_e_end  = early_valid & early_last;
    assign w_f_end  = full_valid & full_last;

    argmax_tracker #(.BIT_SCORE(BIT_SCORE), .N_CLASS(N_CLASS), .BIT_O(BIT_O)) u_early (
        .clock     (clock),
        .reset     (reset),
        .clear     (w_clear),
        .valid     (early_valid),
        .score     ($signed(early_score)),
        .last      (early_last),
        .freeze    (r_state != EA_RUN),
        .max_score (w_e_max),
        .max_idx   (w_e_idx),
        .done      (w_e_done)
    );

    argmax_tracker #(.BIT_SCORE(BIT_SCORE), .N_CLASS(N_CLASS), .BIT_O(BIT_O)) u_full (
        .clock     (clock),
        .reset     (reset),
        .clear     (w_clear),
        .valid     (full_valid),
        .score     ($signed(full_score)),
        .last      (full_last),
        .freeze    (~w_active),
        .max_score (w_f_max),
        .max_idx   (w_f_idx),
        .done      (w_f_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= EA_IDLE;
            r_abort <= 1'b0;
            r_valid <= 1'b0;
            r_early <= 1'b0;
            r_class <= '0;
            r_score <= '0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                EA_IDLE: begin
                    if (start) r_state <= EA_RUN;
                end
                EA_RUN: begin
                    if (start) begin
                        r_state <= EA_RUN;
                    end else if (w_e_end & ~w_e_done) begin
                        if (w_e_max > c_threshold) begin
                            r_valid <= 1'b1;
                            r_early <= 1'b1;
                            r_class <= w_e_idx;
                            r_score <= w_e_max;
                            r_abort <= 1'b1;
                            r_state <= EA_HOLD;
                        end else if (w_f_done | w_f_end) begin
                            r_valid <= 1'b1;
                            r_early <= 1'b0;
                            r_class <= w_f_idx;
                            r_score <= w_f_max;
                            r_state <= EA_HOLD;
                        end else begin
                            r_state <= EA_WAIT;
                        end
                    end
                end
                EA_WAIT: begin
                    if (start) begin
                        r_state <= EA_RUN;
                    end else if (w_f_end) begin
                        r_valid <= 1'b1;
                        r_early <= 1'b0;
                        r_class <= w_f_idx;
                        r_score <= w_f_max;
                        r_state <= EA_HOLD;
                    end
                end
                EA_HOLD: begin
                    // start is deliberately ignored here so a pending decision is never dropped
                    if (class_ready) begin
                        r_valid <= 1'b0;
                        r_state <= EA_IDLE;
                    end
                end
                default: r_state <= EA_IDLE;
            endcase
        end
    end

    assign abort       = r_abort;
    assign class_valid = r_valid;
    assign class_out   = r_class;
    assign class_early = r_early;
    assign class_score = r_score;

endmodule

`default_nettype wire

// File: tb/tb_exit_arbiter.sv
// ============================================================================
// Module   : tb_exit_arbiter
// Purpose  : Directed self-checking bench for exit_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_exit_arbiter;
    import exit_arbiter_pkg::*;

    logic        clock;
    logic        reset;
    logic        start;
    logic        early_valid;
    logic [15:0] early_score;
    logic        early_last;
    logic        full_valid;
    logic [15:0] full_score;
    logic        full_last;
    logic        abort;
    logic        class_valid;
    logic        class_ready;
    logic [3:0]  class_out;
    logic        class_early;
    logic [15:0] class_score;

    int checks   = 0;
    int failures = 0;
    int vec [10];

    exit_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .early_valid (early_valid),
        .early_score (early_score),
        .early_last  (early_last),
        .full_valid  (full_valid),
        .full_score  (full_score),
        .full_last   (full_last),
        .abort       (abort),
        .class_valid (class_valid),
        .class_ready (class_ready),
        .class_out   (class_out),
        .class_early (class_early),
        .class_score (class_score)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Streams vec[] into one head; noise drives ignorable early beats alongside.
    task automatic send(input bit is_early, input bit with_last, input bit noise);
        for (int i = 0; i < 10; i++) begin
            if (is_early) begin
                early_valid = 1'b1;
                early_score = 16'(vec[i]);
                early_last  = with_last && (i == 9);
            end else begin
                full_valid = 1'b1;
                full_score = 16'(vec[i]);
                full_last  = with_last && (i == 9);
                if (noise) begin
                    early_valid = 1'b1;
                    early_score = 16'sd100;
                    early_last  = 1'b1;
                end
            end
            step();
        end
        early_valid = 1'b0;
        early_last  = 1'b0;
        full_valid  = 1'b0;
        full_last   = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        early_valid = 1'b0;
        early_score = '0;
        early_last  = 1'b0;
        full_valid  = 1'b0;
        full_score  = '0;
        full_last   = 1'b0;
        class_ready = 1'b0;
        repeat (3) step();
        chk("reset_valid", class_valid, 0);
        chk("reset_out",   class_out,   0);
        chk("reset_early", class_early, 0);
        chk("reset_score", class_score, 0);
        chk("reset_abort", abort,       0);
        chk("reset_state", dut.r_state, EA_IDLE);
        reset = 1'b1;
        step();

        // Early exit
        class_ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        chk("ee_run", dut.r_state, EA_RUN);
        chk("ee_no_abort", abort, 0);
        vec = '{5, 90, 12, 3, 7, 1, 0, 2, 4, 6};
        send(1'b1, 1'b1, 1'b0);
        chk("ee_valid", class_valid, 1);
        chk("ee_abort", abort,       1);
        chk("ee_out",   class_out,   1);
        chk("ee_early", class_early, 1);
        chk("ee_score", $signed(class_score), 90);
        step();
        chk("ee_abort_drop", abort,       0);
        chk("ee_valid_drop", class_valid, 0);
        chk("ee_idle",       dut.r_state, EA_IDLE);

        // Threshold boundary: 70 is not above threshold
        start = 1'b1; step(); start = 1'b0;
        vec = '{70, 10, 20, -5, 0, 69, 3, 4, 5, 6};
        send(1'b1, 1'b1, 1'b0);
        chk("th_wait",  dut.r_state, EA_WAIT);
        chk("th_abort", abort,       0);
        chk("th_valid", class_valid, 0);
        class_ready = 1'b0;
        vec = '{1, 2, 3, 4, 5, 6, 7, 33, 8, -1};
        send(1'b0, 1'b1, 1'b1);
        chk("th_fvalid", class_valid, 1);
        chk("th_out",    class_out,   7);
        chk("th_early",  class_early, 0);
        chk("th_score",  $signed(class_score), 33);
        chk("th_fabort", abort,       0);

        // Backpressure with start and beats while holding
        for (int k = 0; k < 5; k++) begin
            start       = (k == 2);
            full_valid  = 1'b1;
            full_last   = 1'b1;
            full_score  = 16'sd100;
            step();
            chk("bp_valid", class_valid, 1);
            chk("bp_out",   class_out,   7);
            chk("bp_score", $signed(class_score), 33);
            chk("bp_state", dut.r_state, EA_HOLD);
        end
        start       = 1'b0;
        full_valid  = 1'b0;
        full_last   = 1'b0;
        class_ready = 1'b1;
        step();
        chk("bp_release_valid", class_valid, 0);
        chk("bp_release_state", dut.r_state, EA_IDLE);

        // Full stream completes before early last
        start = 1'b1; step(); start = 1'b0;
        vec = '{3, 4, 50, -2, 0, 1, 9, 8, 7, 6};
        send(1'b0, 1'b1, 1'b0);
        chk("ff_run",   dut.r_state, EA_RUN);
        chk("ff_wait0", class_valid, 0);
        vec = '{10, 40, -5, 0, 0, 0, 0, 0, 0, 0};
        send(1'b1, 1'b1, 1'b0);
        chk("ff_valid", class_valid, 1);
        chk("ff_out",   class_out,   2);
        chk("ff_early", class_early, 0);
        chk("ff_score", $signed(class_score), 50);
        chk("ff_abort", abort,       0);
        step();

        // Ties and negatives
        start = 1'b1; step(); start = 1'b0;
        vec = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send(1'b1, 1'b1, 1'b0);
        chk("tn_wait", dut.r_state, EA_WAIT);
        vec = '{-3, -3, -3, -3, -3, -3, -3, -3, -3, -3};
        send(1'b0, 1'b1, 1'b0);
        chk("tn_out",   class_out,   0);
        chk("tn_score", $signed(class_score), -3);
        chk("tn_early", class_early, 0);
        step();

        // Restart mid-RUN clears the trackers
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            early_valid = 1'b1;
            early_score = 16'sd100;
            step();
        end
        early_valid = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("rs_abort", abort,       0);
        chk("rs_state", dut.r_state, EA_RUN);
        chk("rs_valid", class_valid, 0);
        vec = '{10, 20, 80, 5, 5, 5, 5, 5, 5, 5};
        send(1'b1, 1'b1, 1'b0);
        chk("rs_out",     class_out,   2);
        chk("rs_score",   $signed(class_score), 80);
        chk("rs_early",   class_early, 1);
        chk("rs_abort_x", abort,       1);
        step();

        // Asynchronous reset during WAIT_FULL
        start = 1'b1; step(); start = 1'b0;
        vec = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send(1'b1, 1'b1, 1'b0);
        chk("rw_state", dut.r_state, EA_WAIT);
        #2 reset = 1'b0;
        #1;
        chk("rr_state", dut.r_state, EA_IDLE);
        chk("rr_out",   class_out,   0);
        chk("rr_score", class_score, 0);
        chk("rr_early", class_early, 0);
        chk("rr_valid", class_valid, 0);
        chk("rr_abort", abort,       0);
        step();
        reset = 1'b1;
        step();
        chk("rr_release_state", dut.r_state, EA_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/exit_arbiter.md
# exit_arbiter

Final decision stage of the early-termination CNN pipeline, directly downstream of the early-exit dense head (layer3E) and the full-path dense head (layer6F). It consumes each head's serial class-score stream, tracks a running argmax per head, and decides whether the early result is confident enough to publish. On an early exit it pulses `abort` so the full path can stop. Otherwise it waits for the full head. The chosen class is presented on a valid/ready output port.

## Interface
Parameters:
- `BIT_SCORE`, 16: width of a signed class score.
- `N_CLASS`, 10: number of classes per head.
- `BIT_O`, `$clog2(N_CLASS)` = 4: class index width.
- `THRESHOLD`, 70: signed early-exit confidence threshold.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low.
- `start`  in  1: one-cycle pulse that begins a new image.
- `early_valid`  in  1: early-head score beat.
- `early_score`  in  `BIT_SCORE`: signed early-head score.
- `early_last`  in  1: final early beat; qualified by `early_valid`.
- `full_valid`  in  1: full-head score beat.
- `full_score`  in  `BIT_SCORE`: signed full-head score.
- `full_last`  in  1: final full beat; qualified by `full_valid`.
- `abort`  out  1: one-cycle pulse when the early head exits.
- `class_valid`  out  1: decision available.
- `class_ready`  in  1: downstream accepts the decision.
- `class_out`  out  `BIT_O`: winning class index.
- `class_early`  out  1: 1 means the decision came from the early head.
- `class_score`  out  `BIT_SCORE`: winning score.

## Operation
- FSM states: IDLE, RUN, WAIT_FULL, HOLD.
- **IDLE**
  - `start` moves the FSM to RUN.
  - Both argmax trackers and the `full_done` flag are cleared.
  - Beats arriving in IDLE are ignored.
- **Argmax trackers (one per head)**
  - Each tracker holds an index counter (0..`N_CLASS`-1), `max_score` and `max_idx`.
  - Every valid beat increments the counter.
  - The first beat loads the maximum unconditionally.
  - Later beats update the maximum only if the score is signed and strictly greater, so ties keep the lowest index.
  - Beats after `N_CLASS` without `last` are ignored; the counter saturates.
  - `last` before `N_CLASS` beats ends the stream; the argmax covers only the beats received.
- **RUN**
  - Both trackers accept beats.
  - On `full_valid & full_last`, set `full_done` and freeze the full tracker.
  - On `early_valid & early_last`, form the final early max, including that beat. Then:
    - Early max > `THRESHOLD` (signed, strict): latch the early result with `class_early`=1, pulse `abort`, go to HOLD.
    - Else, if `full_done`: latch the full result with `class_early`=0, go to HOLD.
    - Else: go to WAIT_FULL.
- **WAIT_FULL**
  - Early beats are ignored.
  - On `full_valid & full_last`, latch the full argmax (including that beat) with `class_early`=0 and go to HOLD.
- **HOLD**
  - `class_valid`=1; outputs stay stable until `class_ready`.
  - Handshake completes on `class_valid & class_ready`; the FSM returns to IDLE.
  - All input beats are ignored.
  - `start` is ignored, so a decision is never lost.
- **`start` in RUN or WAIT_FULL:** restart. Trackers and `full_done` are cleared, the state goes to RUN, and `abort` is not asserted.
- **Simultaneous early-last and full-last in RUN:** the early exit wins if above threshold; otherwise the full result is used in the same cycle.
- **Arithmetic:** signed compares only. `class_score` carries the winner's score unmodified; there is no saturation.

## Timing
- Outputs reset (reset low) to: `class_valid`=0, `class_out`=0, `class_early`=0, `class_score`=0, `abort`=0, state IDLE.
- All outputs are registered.
- A deciding last beat in cycle t gives `class_valid`=1 in cycle t+1.
- On an early exit, `abort` is high in cycle t+1 only.
- The handshake accepted in cycle t gives `class_valid`=0 and state IDLE at t+1.
- `start` can be accepted in that same t+1 cycle.
- Reset assertion mid-operation immediately clears the state and all outputs; no partial decision survives.

## Structure
- Shared `definitions.v` holds:
  - FSM state encodings `EA_IDLE`, `EA_RUN`, `EA_WAIT`, `EA_HOLD`.
  - `EXIT_THRESHOLD` (70), alongside the existing `BIT_O` and `BIT_RLRE`.
- Sub-module `argmax_tracker`: parameters `BIT_SCORE`, `N_CLASS`; ports `clear`, `valid`, `score`, `last`, `freeze`; outputs `max_score`, `max_idx`, `done`. Instantiated twice.

## Test plan
- **Early exit:** start; early scores [5,90,12,…] with last on beat 10; class_ready=1. Required: class_out=1, class_early=1, class_score=90; abort high exactly one cycle, the same cycle as class_valid.
- **Threshold boundary:** early max exactly 70 → WAIT_FULL, no abort. Then full scores with max 33 at index 7 → class_out=7, class_early=0.
- **Full stream first:** full stream completes (max at index 2) before early last; early max 40. Required: class_valid one cycle after early last; class_out=2, class_early=0.
- **Ties and negatives:** full scores all −3. Required: class_out=0, class_score=−3.
- **Backpressure:** class_ready=0 for 5 cycles. Required: outputs stable, start ignored in HOLD, FSM returns to IDLE the cycle after ready.
- **Restart and reset:** start mid-RUN after 4 early beats → trackers cleared, no abort. reset low during WAIT_FULL → all outputs 0 and IDLE.
